seg7_scan_driver: RTL and testbench

//   Memory-mapped 8-digit 7-segment display controller on the bus bridge's dig port.

---
 rtl/seg7_scan_driver.sv | 107 ++++++++++
 tb/tb_seg7_scan_driver.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// 8-digit hex 7-segment scan driver: latches a 32-bit word written to DIG_ADDR and scans it out one digit per slot.
// Optional build macro SEG7_BLANK_LEADING_ZERO_EN blanks digits above the highest nonzero nibble.
module seg7_scan_driver #(
    parameter logic [31:0] DIG_ADDR   = 32'hFFFF_F000,
    parameter int          SCAN_DIV   = 20000,
    parameter int          NUM_DIGITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [7:0]  dig_en,
    output logic [7:0]  dig_seg
);
    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [31:0]      data_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [7:0]       dig_en_reg;
    logic [7:0]       dig_seg_reg;
    logic [7:0]       dig_en_next;
    logic [7:0]       dig_seg_next;
    logic [3:0]       nibble [NUM_DIGITS];
    logic             blank;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nibble
            assign nibble[gi] = data_reg[4*gi +: 4];
        end
    endgenerate

    // Active-low {g,f,e,d,c,b,a}; dp is prepended by the caller.
    function automatic logic [6:0] hexdec(input logic [3:0] v);
        case (v)
            4'h0:    hexdec = 7'h40;
            4'h1:    hexdec = 7'h79;
            4'h2:    hexdec = 7'h24;
            4'h3:    hexdec = 7'h30;
            4'h4:    hexdec = 7'h19;
            4'h5:    hexdec = 7'h12;
            4'h6:    hexdec = 7'h02;
            4'h7:    hexdec = 7'h78;
            4'h8:    hexdec = 7'h00;
            4'h9:    hexdec = 7'h10;
            4'hA:    hexdec = 7'h08;
            4'hB:    hexdec = 7'h03;
            4'hC:    hexdec = 7'h46;
            4'hD:    hexdec = 7'h21;
            4'hE:    hexdec = 7'h06;
            default: hexdec = 7'h0E;
        endcase
    endfunction

`ifdef SEG7_BLANK_LEADING_ZERO_EN
    logic [NUM_DIGITS-1:0] nz;
    logic [IDX_W-1:0]      top_idx;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nz
            assign nz[gi] = |nibble[gi];
        end
    endgenerate

    // Highest nonzero digit; digit 0 stays lit even when the word is zero.
    always_comb begin
        top_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (nz[i]) top_idx = IDX_W'(i);
        end
        blank = (idx_reg > top_idx);
    end
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        dig_en_next  = ~(8'b1 << idx_reg);
        dig_seg_next = blank ? 8'hFF : {1'b1, hexdec(nibble[idx_reg])};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            data_reg    <= '0;
            cnt_reg     <= '0;
            idx_reg     <= '0;
            dig_en_reg  <= 8'hFF;
            dig_seg_reg <= 8'hFF;
        end else begin
            if (we && (addr == DIG_ADDR)) data_reg <= wdata;
            if (cnt_reg == CNT_LAST) begin
                cnt_reg <= '0;
                idx_reg <= idx_reg + IDX_W'(1);
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
            dig_en_reg  <= dig_en_next;
            dig_seg_reg <= dig_seg_next;
        end
    end

    assign dig_en  = dig_en_reg;
    assign dig_seg = dig_seg_reg;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized self-checking bench for seg7_scan_driver (SCAN_DIV=4) against a slot-arithmetic reference model.
// Honours SEG7_BLANK_LEADING_ZERO_EN when the build defines it.
module tb_seg7_scan_driver;
    localparam logic [31:0] DIG_ADDR = 32'hFFFF_F000;
    localparam int          SCAN_DIV = 4;
    localparam int          PERIOD   = SCAN_DIV * 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [7:0]  dig_en;
    logic [7:0]  dig_seg;

    int checks = 0;
    int errors = 0;

    seg7_scan_driver #(
        .DIG_ADDR  (DIG_ADDR),
        .SCAN_DIV  (SCAN_DIV),
        .NUM_DIGITS(8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .addr   (addr),
        .we     (we),
        .wdata  (wdata),
        .dig_en (dig_en),
        .dig_seg(dig_seg)
    );

    always #5 clk = ~clk;

    // Reference model: slot index is the number of edges since reset divided by SCAN_DIV.
    logic [7:0] seg_lut [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    logic [7:0] pat_1234 [8] = '{8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};

    int          mj = 0;
    logic [31:0] mdata = '0;
    logic [7:0]  exp_en = 8'hFF;
    logic [7:0]  exp_seg = 8'hFF;

    function automatic logic [7:0] ref_seg(input logic [31:0] d, input int idx);
        logic [3:0] nib;
`ifdef SEG7_BLANK_LEADING_ZERO_EN
        int m = 0;
        for (int i = 0; i < 8; i++) if (((d >> (4*i)) & 32'hF) != 0) m = i;
        if (idx > m) return 8'hFF;
`endif
        nib = 4'((d >> (4*idx)) & 32'hF);
        return seg_lut[nib];
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            mj      <= 0;
            mdata   <= '0;
            exp_en  <= 8'hFF;
            exp_seg <= 8'hFF;
        end else begin
            mj      <= mj + 1;
            exp_en  <= ~(8'd1 << ((mj / SCAN_DIV) % 8));
            exp_seg <= ref_seg(mdata, (mj / SCAN_DIV) % 8);
            if (we && addr == DIG_ADDR) mdata <= wdata;
        end
    end

    // Digit shown by the current outputs (driven from the previous edge's slot).
    function automatic int shown_digit();
        return ((mj - 1) / SCAN_DIV) % 8;
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (dig_en !== 8'hFF || dig_seg !== 8'hFF) begin
            errors++;
            $display("FAIL reset_hold dig_en=%h dig_seg=%h expected FF FF", dig_en, dig_seg);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (dig_en !== 8'hFE || dig_seg !== 8'hC0) begin
            errors++;
            $display("FAIL reset_release dig_en=%h dig_seg=%h expected FE C0", dig_en, dig_seg);
        end
    endtask

    task automatic test_pattern();
        we = 1'b1; addr = DIG_ADDR; wdata = 32'h1234_5678;
        $display("write addr=%h data=%h", addr, wdata);
        @(negedge clk);
        we = 1'b0;
        for (int i = 0; i < 40; i++) begin
            checks++;
            if (dig_en !== exp_en || dig_seg !== exp_seg) begin
                errors++;
                $display("FAIL pattern cyc=%0d dig_en=%h dig_seg=%h expected %h %h", i, dig_en, dig_seg, exp_en, exp_seg);
            end
            if (i >= 1) begin
                checks++;
                if (dig_seg !== pat_1234[shown_digit()]) begin
                    errors++;
                    $display("FAIL pattern_table digit=%0d dig_seg=%h expected %h", shown_digit(), dig_seg, pat_1234[shown_digit()]);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_bad_addr();
        we = 1'b1; addr = 32'hFFFF_F060; wdata = 32'hFFFF_FFFF;
        $display("write addr=%h data=%h", addr, wdata);
        @(negedge clk);
        we = 1'b0;
        for (int i = 0; i < 36; i++) begin
            checks++;
            if (dig_en !== exp_en || dig_seg !== pat_1234[shown_digit()]) begin
                errors++;
                $display("FAIL bad_addr cyc=%0d dig_en=%h dig_seg=%h expected %h %h", i, dig_en, dig_seg, exp_en, pat_1234[shown_digit()]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_wrap_write();
        for (int n = 0; n < 2 * PERIOD && (mj % PERIOD) != 3; n++) @(negedge clk);
        checks++;
        if ((mj % PERIOD) != 3) begin
            errors++;
            $display("FAIL wrap_wait slot=%0d expected 3", mj % PERIOD);
        end
        we = 1'b1; addr = DIG_ADDR; wdata = 32'hDEAD_BEEF;
        $display("write addr=%h data=%h", addr, wdata);
        @(negedge clk);
        we = 1'b0;
        @(negedge clk);
        checks++;
        if (dig_en !== 8'hFD || dig_seg !== 8'h86) begin
            errors++;
            $display("FAIL wrap_write dig_en=%h dig_seg=%h expected FD 86", dig_en, dig_seg);
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            checks++;
            if (dig_en !== exp_en || dig_seg !== exp_seg) begin
                errors++;
                $display("FAIL wrap_follow cyc=%0d dig_en=%h dig_seg=%h expected %h %h", i, dig_en, dig_seg, exp_en, exp_seg);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int n = 0; n < 2 * PERIOD && (mj % PERIOD) != 21; n++) @(negedge clk);
        checks++;
        if ((mj % PERIOD) != 21) begin
            errors++;
            $display("FAIL midreset_wait slot=%0d expected 21", mj % PERIOD);
        end
        rst = 1'b0; we = 1'b1; addr = DIG_ADDR; wdata = 32'h5555_5555;
        @(negedge clk);
        we = 1'b0;
        checks++;
        if (dig_en !== 8'hFF || dig_seg !== 8'hFF) begin
            errors++;
            $display("FAIL midreset dig_en=%h dig_seg=%h expected FF FF", dig_en, dig_seg);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (dig_en !== 8'hFE || dig_seg !== 8'hC0) begin
            errors++;
            $display("FAIL midreset_release dig_en=%h dig_seg=%h expected FE C0", dig_en, dig_seg);
        end
        for (int i = 0; i < PERIOD; i++) begin
            @(negedge clk);
            checks++;
            if (dig_en !== exp_en || dig_seg !== exp_seg) begin
                errors++;
                $display("FAIL midreset_scan cyc=%0d dig_en=%h dig_seg=%h expected %h %h", i, dig_en, dig_seg, exp_en, exp_seg);
            end
        end
    endtask

    task automatic test_blank();
        logic [31:0] words [2] = '{32'h0000_00A5, 32'h0000_0000};
        logic [7:0]  want;
        for (int w = 0; w < 2; w++) begin
            we = 1'b1; addr = DIG_ADDR; wdata = words[w];
            $display("write addr=%h data=%h", addr, wdata);
            @(negedge clk);
            we = 1'b0;
            @(negedge clk);
            for (int i = 0; i < PERIOD + 2; i++) begin
                if (shown_digit() == 0) want = (w == 0) ? 8'h92 : 8'hC0;
                else if (shown_digit() == 1 && w == 0) want = 8'h88;
                else begin
`ifdef SEG7_BLANK_LEADING_ZERO_EN
                    want = 8'hFF;
`else
                    want = 8'hC0;
`endif
                end
                checks++;
                if (dig_seg !== want || dig_seg !== exp_seg || dig_en !== exp_en) begin
                    errors++;
                    $display("FAIL blank word=%h digit=%0d dig_en=%h dig_seg=%h expected %h %h", words[w], shown_digit(), dig_en, dig_seg, exp_en, want);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            checks++;
            if (dig_en !== exp_en || dig_seg !== exp_seg) begin
                errors++;
                $display("FAIL random cyc=%0d dig_en=%h dig_seg=%h expected %h %h", i, dig_en, dig_seg, exp_en, exp_seg);
            end
            rst   = ($urandom_range(0, 149) != 0);
            we    = ($urandom_range(0, 5) == 0);
            addr  = ($urandom_range(0, 3) != 0) ? DIG_ADDR : ($urandom | 32'h1);
            wdata = $urandom >> (4 * $urandom_range(0, 8));
            if (we) $display("write addr=%h data=%h rst=%0d", addr, wdata, rst);
            @(negedge clk);
        end
        rst = 1'b1; we = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_pattern();
        test_bad_addr();
        test_wrap_write();
        test_reset_mid();
        test_blank();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
